jtag_dr_bank: RTL and testbench
===============================

# jtag_dr_bank

Parametrised JTAG data-register bank. It holds a 1-bit bypass register and NUM_DR user data registers of DR_WIDTH bits each. Each user register has its own capture/shift stage and update stage. It sits between the TAP controller (which supplies the capture/shift/update strobes and the decoded select from the instruction register) and the TDO output path, and presents the selected register's serial output on tdo. It also adds per-register update pulses, a shifted-bit counter and out-of-range select detection.

## Interface
Parameters:
- NUM_DR, default 2: number of user data registers (1..15).
- DR_WIDTH, default 8: bits per user data register (≥ 2).
- SEL_W, derived as clog2(NUM_DR+1): select width.
- CNT_W, derived as clog2(DR_WIDTH)+1: shift counter width.

Ports:
- tck, input, 1: the single clock (JTAG TCK); all state changes on its rising edge.
- trst_n, input, 1: reset, asynchronous, active-low.
- test_logic_reset, input, 1: synchronous clear from the TAP (Test-Logic-Reset state).
- capture_dr, input, 1: TAP in Capture-DR.
- shift_dr, input, 1: TAP in Shift-DR.
- update_dr, input, 1: TAP in Update-DR.
- sel, input, SEL_W: 0 = bypass; k in 1..NUM_DR = user register k-1; values above NUM_DR are invalid.
- tdi, input, 1: serial data in.
- cap_data, input, NUM_DR*DR_WIDTH: parallel capture values; slice k holds bits [k*DR_WIDTH +: DR_WIDTH].
- upd_data, output, NUM_DR*DR_WIDTH: update-stage contents, same slicing as cap_data.
- upd_valid, output, NUM_DR: one-cycle pulse per register on update.
- tdo, output, 1: serial data out.
- tdo_en, output, 1: equals shift_dr.
- shift_cnt, output, CNT_W: bits shifted since the last capture, saturating.
- sel_err, output, 1: sticky flag for an invalid select.

## Operation
- Effective select: sel if sel ≤ NUM_DR, else 0 (bypass).
- Strobe priority per cycle: test_logic_reset, then capture_dr, then shift_dr, then update_dr. A lower-priority strobe asserted together with a higher one is ignored.
- test_logic_reset clears the following:
  - all shift stages, bypass, upd_data, shift_cnt and sel_err;
  - upd_valid is forced to 0.
- Capture:
  - A selected user register k loads its cap_data slice k into its shift stage.
  - If bypass is selected, bypass loads 0.
  - shift_cnt is cleared to 0.
  - If sel > NUM_DR, sel_err is set.
- Shift:
  - A selected user register shifts right: tdi enters the MSB and the LSB is discarded.
  - If bypass is selected, bypass takes tdi.
  - shift_cnt increments and saturates at 2^CNT_W-1.
- Update:
  - A selected user register k copies its shift stage into upd_data slice k, and upd_valid[k] is 1 in the following cycle only.
  - Update with bypass selected (including invalid sel) changes nothing.
- Non-selected registers hold both their shift stage and their update stage in every case.
- tdo is combinational: the LSB of the selected register's shift stage, or the bypass bit. It is valid while shift_dr is high and in the cycle before shifting starts.
- sel changing mid-scan takes effect immediately. No state is lost; the newly selected register simply becomes active.

## Timing
- Reset values: every shift stage is 0, bypass 0, upd_data all 0, upd_valid 0, shift_cnt 0, sel_err 0. tdo is therefore 0; tdo_en follows shift_dr.
- trst_n clears asynchronously, including mid-shift. Release is synchronous to tck.
- Capture-to-first-bit: after the capture edge, tdo already shows bit 0 of the captured value. Each subsequent shift edge advances tdo by one bit.
- Bypass latency: a bit presented on tdi appears on tdo exactly one shift cycle later.
- User register latency: DR_WIDTH shift cycles from a bit on tdi to that bit on tdo.
- upd_data changes on the update edge. upd_valid is a registered pulse, high for exactly one cycle after that edge.
- Back-to-back update cycles produce back-to-back pulses.
- sel_err stays set until trst_n or test_logic_reset clears it.

## Test plan
- Reset mid-scan: NUM_DR=2, DR_WIDTH=8, sel=1, capture cap_data=16'h00A5, shift 3 bits, then pull trst_n low. Required: all outputs 0 immediately, without a tck edge.
- Bypass: sel=0, capture, then shift tdi=1,0,1,1. Required: tdo=0,1,0,1 over those cycles; shift_cnt=4; upd_valid stays 0 on update.
- User register round trip:
  - Stimulus: sel=1, cap_data=16'h77A5, capture, shift 8 bits of 0x3C LSB-first, then update.
  - Required: tdo=1,0,1,0,0,1,0,1; upd_data=16'h003C; upd_valid=2'b01 for one cycle; upd_data[15:8] unchanged.
- Invalid select: sel=3, capture, then shift 1,0. Required: bypass behaviour; sel_err=1 and stays 1 across a subsequent valid scan; 0 after test_logic_reset.
- Counter saturation: sel=2, capture, then shift 20 cycles. Required: shift_cnt reaches 15 and holds; upd_data[15:8] equals the last 8 tdi bits after update.
- Simultaneous strobes: capture_dr and update_dr high in the same cycle with sel=1. Required: the capture occurs, upd_data is unchanged and upd_valid stays 0.

Source files
------------

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: a bypass bit plus NUM_DR user registers, each with
// a capture/shift stage and an update stage, selected by the decoded IR value.
module jtag_dr_bank #(
  parameter int unsigned NUM_DR   = 2,
  parameter int unsigned DR_WIDTH = 8,
  localparam int unsigned SEL_W   = $clog2(NUM_DR + 1),
  localparam int unsigned CNT_W   = $clog2(DR_WIDTH) + 1,
  localparam int unsigned BANK_W  = NUM_DR * DR_WIDTH
) (
  input  logic              tck,
  input  logic              trst_n,
  input  logic              test_logic_reset,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic [SEL_W-1:0]  sel,
  input  logic              tdi,
  input  logic [BANK_W-1:0] cap_data,
  output logic [BANK_W-1:0] upd_data,
  output logic [NUM_DR-1:0] upd_valid,
  output logic              tdo,
  output logic              tdo_en,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              sel_err
);

  logic [BANK_W-1:0] sr_q,  sr_d;
  logic [BANK_W-1:0] upd_q, upd_d;
  logic [NUM_DR-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byp_q, byp_d;
  logic              err_q, err_d;

  logic              sel_bad;
  logic [SEL_W-1:0]  sel_eff;

  // Out-of-range selects fall back to bypass.
  assign sel_bad = (sel > SEL_W'(NUM_DR));
  assign sel_eff = sel_bad ? '0 : sel;

  // Strobe priority: reset, capture, shift, update.
  always_comb begin
    sr_d  = sr_q;
    upd_d = upd_q;
    vld_d = '0;
    cnt_d = cnt_q;
    byp_d = byp_q;
    err_d = err_q;
    if (test_logic_reset) begin
      sr_d  = '0;
      upd_d = '0;
      cnt_d = '0;
      byp_d = 1'b0;
      err_d = 1'b0;
    end else if (capture_dr) begin
      if (sel_eff == '0) byp_d = 1'b0;
      for (int k = 0; k < int'(NUM_DR); k++) begin
        if (sel_eff == SEL_W'(k + 1))
          sr_d[k*DR_WIDTH +: DR_WIDTH] = cap_data[k*DR_WIDTH +: DR_WIDTH];
      end
      cnt_d = '0;
      if (sel_bad) err_d = 1'b1;
    end else if (shift_dr) begin
      if (sel_eff == '0) byp_d = tdi;
      for (int k = 0; k < int'(NUM_DR); k++) begin
        if (sel_eff == SEL_W'(k + 1))
          sr_d[k*DR_WIDTH +: DR_WIDTH] = {tdi, sr_q[k*DR_WIDTH+1 +: DR_WIDTH-1]};
      end
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (update_dr) begin
      for (int k = 0; k < int'(NUM_DR); k++) begin
        if (sel_eff == SEL_W'(k + 1)) begin
          upd_d[k*DR_WIDTH +: DR_WIDTH] = sr_q[k*DR_WIDTH +: DR_WIDTH];
          vld_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sr_q  <= '0;
      upd_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
      byp_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      byp_q <= byp_d;
      err_q <= err_d;
    end
  end

  // Serial output comes straight from the selected stage so bit 0 is visible right after capture.
  always_comb begin
    tdo = byp_q;
    for (int k = 0; k < int'(NUM_DR); k++) begin
      if (sel_eff == SEL_W'(k + 1)) tdo = sr_q[k*DR_WIDTH];
    end
  end

  assign tdo_en    = shift_dr;
  assign upd_data  = upd_q;
  assign upd_valid = vld_q;
  assign shift_cnt = cnt_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank (NUM_DR=2, DR_WIDTH=8).
module tb_jtag_dr_bank;

  logic        tck = 1'b0;
  logic        trst_n;
  logic        test_logic_reset;
  logic        capture_dr;
  logic        shift_dr;
  logic        update_dr;
  logic [1:0]  sel;
  logic        tdi;
  logic [15:0] cap_data;
  logic [15:0] upd_data;
  logic [1:0]  upd_valid;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  shift_cnt;
  logic        sel_err;

  int vectors = 0;
  int miscompares = 0;

  jtag_dr_bank #(.NUM_DR(2), .DR_WIDTH(8)) dut (
    .tck              (tck),
    .trst_n           (trst_n),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .sel              (sel),
    .tdi              (tdi),
    .cap_data         (cap_data),
    .upd_data         (upd_data),
    .upd_valid        (upd_valid),
    .tdo              (tdo),
    .tdo_en           (tdo_en),
    .shift_cnt        (shift_cnt),
    .sel_err          (sel_err)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input logic cap, input logic sh, input logic upd);
    capture_dr = cap;
    shift_dr   = sh;
    update_dr  = upd;
  endtask

  initial begin
    logic [7:0]  bits8;
    logic [19:0] pat;
    logic [7:0]  cap8;

    trst_n = 1'b0;
    test_logic_reset = 1'b0;
    strobes(1'b0, 1'b0, 1'b0);
    sel = 2'd0;
    tdi = 1'b0;
    cap_data = 16'h0000;
    #2;
    check("rst_tdo", 32'(tdo), 32'h0);
    check("rst_upd_data", 32'(upd_data), 32'h0);
    check("rst_cnt", 32'(shift_cnt), 32'h0);
    tick();
    trst_n = 1'b1;
    tick();

    // Reset mid-scan
    sel = 2'd1;
    cap_data = 16'h00A5;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    check("mid_cap_tdo", 32'(tdo), 32'h1);
    strobes(1'b0, 1'b1, 1'b0);
    tdi = 1'b1;
    tick(); tick(); tick();
    check("mid_cnt_pre", 32'(shift_cnt), 32'h3);
    trst_n = 1'b0;
    #1;
    check("mid_rst_tdo", 32'(tdo), 32'h0);
    check("mid_rst_cnt", 32'(shift_cnt), 32'h0);
    check("mid_rst_upd", 32'(upd_data), 32'h0);
    check("mid_rst_vld", 32'(upd_valid), 32'h0);
    check("mid_rst_err", 32'(sel_err), 32'h0);
    check("mid_rst_tdo_en", 32'(tdo_en), 32'h1);
    strobes(1'b0, 1'b0, 1'b0);
    tick();
    trst_n = 1'b1;
    tick();

    // Bypass
    sel = 2'd0;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b1, 1'b0);
    tdi = 1'b1; check("byp_tdo0", 32'(tdo), 32'h0); tick();
    tdi = 1'b0; check("byp_tdo1", 32'(tdo), 32'h1); tick();
    tdi = 1'b1; check("byp_tdo2", 32'(tdo), 32'h0); tick();
    tdi = 1'b1; check("byp_tdo3", 32'(tdo), 32'h1); tick();
    check("byp_cnt", 32'(shift_cnt), 32'h4);
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    check("byp_upd_vld", 32'(upd_valid), 32'h0);
    check("byp_upd_data", 32'(upd_data), 32'h0);
    strobes(1'b0, 1'b0, 1'b0);
    tick();

    // User register round trip
    sel = 2'd1;
    cap_data = 16'h77A5;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b1, 1'b0);
    bits8 = 8'h3C;
    cap8  = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tdi = bits8[i];
      check($sformatf("rt_tdo%0d", i), 32'(tdo), 32'(cap8[i]));
      tick();
    end
    check("rt_cnt", 32'(shift_cnt), 32'h8);
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    check("rt_upd_data", 32'(upd_data), 32'h003C);
    check("rt_vld_pulse", 32'(upd_valid), 32'h1);
    strobes(1'b0, 1'b0, 1'b0);
    tick();
    check("rt_vld_drop", 32'(upd_valid), 32'h0);

    // Invalid select
    sel = 2'd3;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    check("inv_err_set", 32'(sel_err), 32'h1);
    strobes(1'b0, 1'b1, 1'b0);
    tdi = 1'b1; check("inv_tdo0", 32'(tdo), 32'h0); tick();
    tdi = 1'b0; check("inv_tdo1", 32'(tdo), 32'h1); tick();
    check("inv_tdo2", 32'(tdo), 32'h0);
    sel = 2'd1;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b1, 1'b0);
    tick();
    check("inv_err_sticky", 32'(sel_err), 32'h1);
    strobes(1'b0, 1'b0, 1'b0);
    test_logic_reset = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    check("tlr_err_clr", 32'(sel_err), 32'h0);
    check("tlr_upd_clr", 32'(upd_data), 32'h0);
    check("tlr_cnt_clr", 32'(shift_cnt), 32'h0);

    // Counter saturation and register 1 latency
    sel = 2'd2;
    cap_data = 16'h77A5;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b1, 1'b0);
    pat  = 20'hC95A3;
    cap8 = 8'h77;
    for (int i = 0; i < 20; i++) begin
      tdi = pat[i];
      if (i < 8) check($sformatf("sat_tdo%0d", i), 32'(tdo), 32'(cap8[i]));
      else       check($sformatf("sat_tdo%0d", i), 32'(tdo), 32'(pat[i-8]));
      tick();
      if (i == 14) check("sat_cnt15", 32'(shift_cnt), 32'hF);
    end
    check("sat_cnt_hold", 32'(shift_cnt), 32'hF);
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    check("sat_upd_data", 32'(upd_data), 32'hC900);
    check("sat_vld", 32'(upd_valid), 32'h2);
    strobes(1'b0, 1'b0, 1'b0);
    tick();

    // Capture and update together: capture wins
    sel = 2'd1;
    cap_data = 16'h1235;
    strobes(1'b1, 1'b0, 1'b1);
    tick();
    check("sim_tdo", 32'(tdo), 32'h1);
    check("sim_cnt", 32'(shift_cnt), 32'h0);
    check("sim_upd_data", 32'(upd_data), 32'hC900);
    check("sim_vld", 32'(upd_valid), 32'h0);

    // Back-to-back updates
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    check("b2b_vld0", 32'(upd_valid), 32'h1);
    tick();
    check("b2b_vld1", 32'(upd_valid), 32'h1);
    check("b2b_upd_data", 32'(upd_data), 32'hC935);
    strobes(1'b0, 1'b0, 1'b0);
    tick();
    check("b2b_vld_drop", 32'(upd_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
